snn_spike_rate_decoder: RTL

Output-side decoder for the fixed-point Izhikevich SNN cores (e.g. the 16-bit 2-4-4-2 network). It counts each output neuron's `spike_out` pulses over a fixed observation window and picks the most active neuron as the classification result. The result is presented over a valid/ready handshake. It sits between the SNN core's `spike_out` bus and the system controller or bench scoreboard, and is the counterpart of the input spike stimulus generator.

---
 rtl/snn_spike_rate_decoder_pkg.sv | 16 +
 rtl/spike_counter_sat.sv | 29 ++
 rtl/snn_spike_rate_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/snn_spike_rate_decoder_pkg.sv
// Shared types and default sizing for the SNN output spike-rate decoder.
package snn_decode_pkg;

  localparam int WINDOW_W    = 16;
  localparam int N_OUT_DEF   = 2;
  localparam int CNT_W_DEF   = 8;
  localparam int WINDOW_DEF  = 200;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/spike_counter_sat.sv
// Single saturating spike counter with synchronous clear and count enable.
module spike_counter_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/snn_spike_rate_decoder.sv
// Counts output-neuron spikes over a fixed window, then scans for the most active
// neuron and presents the result over a valid/ready handshake.
module snn_spike_rate_decoder
  import snn_decode_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  localparam int WIN_W = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_OUT-1:0]       spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [WIN_W-1:0]       winner,
  output logic [CNT_W-1:0]       winner_count,
  output logic                   tie,
  output logic                   no_spike,
  output logic [N_OUT*CNT_W-1:0] counts
);

  state_e                state_q, state_d;
  logic [WINDOW_W-1:0]   win_q, win_d;
  logic [WIN_W-1:0]      scan_q, scan_d;
  logic [WIN_W-1:0]      best_idx_q, best_idx_d;
  logic [CNT_W-1:0]      best_cnt_q, best_cnt_d;
  logic                  tie_q, tie_d;
  logic                  nosp_q, nosp_d;
  logic                  clr_cnt;
  logic                  cnt_en;
  logic [CNT_W-1:0]      cur_cnt;
  logic [CNT_W-1:0]      cnt [N_OUT];

  for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
    spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .clr_i (rst | clr_cnt),
      .en_i  (cnt_en & spike_in[i]),
      .cnt_o (cnt[i])
    );
    assign counts[i*CNT_W +: CNT_W] = cnt[i];
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    tie_d      = tie_q;
    nosp_d     = nosp_q;
    clr_cnt    = 1'b0;
    cnt_en     = 1'b0;
    cur_cnt    = cnt[scan_q];
    case (state_q)
      IDLE: begin
        if (start) begin
          clr_cnt = 1'b1;
          win_d   = '0;
          scan_d  = '0;
          tie_d   = 1'b0;
          nosp_d  = 1'b0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        win_d  = win_q + WINDOW_W'(1);
        if (win_q == WINDOW_W'(WINDOW - 1)) begin
          scan_d  = '0;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        // A strictly greater count takes over, so the lowest index keeps a tie;
        // a takeover also drops any tie recorded against the old best.
        if (scan_q == '0) begin
          best_idx_d = '0;
          best_cnt_d = cur_cnt;
          tie_d      = 1'b0;
        end else if (cur_cnt > best_cnt_q) begin
          best_idx_d = scan_q;
          best_cnt_d = cur_cnt;
          tie_d      = 1'b0;
        end else if (cur_cnt == best_cnt_q) begin
          tie_d = 1'b1;
        end
        nosp_d = (best_cnt_d == '0);
        if (scan_q == WIN_W'(N_OUT - 1)) begin
          state_d = HOLD;
        end else begin
          scan_d = scan_q + WIN_W'(1);
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      tie_q      <= 1'b0;
      nosp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      tie_q      <= tie_d;
      nosp_q     <= nosp_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == HOLD);
  assign winner       = best_idx_q;
  assign winner_count = best_cnt_q;
  assign tie          = tie_q;
  assign no_spike     = nosp_q;

endmodule
